// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU (FWD/ADD/AND/OR/SUB, iterative SLL/SRA, optional iterative MUL).
// Latency: 1 cycle for single-cycle ops and zero-amount shifts, 1+n for shifts by n, 1+WIDTH for MUL.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready.
//
// Build option: define ALU_MUL_EN to build the shift-add multiplier for opcode 111.
// Without it, opcode 111 completes in one cycle with result=0, err=1.
//
// Ports:
//   CLK, RESET           clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (data1, data2, operation latched on accept)
//   out_valid / out_ready result handshake (result, co, zero, ovf, err)
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    // Counter must hold WIDTH for the multiplier, one bit more than a shift amount.
    localparam int CW  = SHW + 1;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_sco;       // last bit shifted out so far

    logic [WIDTH-1:0] r_result;
    logic             r_co;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;

    logic             w_accept;
    logic [CW-1:0]    w_init_cnt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_co;
    logic             w_fin_ovf;
    logic             w_fin_err;

`ifdef ALU_MUL_EN
    // {high half, low half}; the low half starts as the multiplier and is
    // consumed LSB-first as partial sums shift in from the top.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_mul_sum;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every accepted op makes one pass through EXEC. Single-cycle ops and
    // zero-amount shifts enter with counter 0, so the pass only registers
    // the result; that gives the 1 / 1+n / 1+WIDTH latencies uniformly.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_comb begin
        w_init_cnt = '0;
        case (operation)
            OP_SLL, OP_SRA: w_init_cnt = {1'b0, data2[SHW-1:0]};
`ifdef ALU_MUL_EN
            OP_MUL:         w_init_cnt = CW'(WIDTH);
`endif
            default:        w_init_cnt = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Final result / flags from the working registers
    // ------------------------------------------------------------------
    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_diff    = r_a - r_b;
        w_fin_res = '0;
        w_fin_co  = 1'b0;
        w_fin_ovf = 1'b0;
        w_fin_err = 1'b0;
        case (r_op)
            OP_FWD: w_fin_res = r_b;
            OP_ADD: begin
                w_fin_res = w_sum[WIDTH-1:0];
                w_fin_co  = w_sum[WIDTH];
                // Same-sign operands producing a different-sign sum.
                w_fin_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: w_fin_res = r_a & r_b;
            OP_OR:  w_fin_res = r_a | r_b;
            OP_SUB: begin
                w_fin_res = w_diff;
                w_fin_co  = (r_a >= r_b);
                // Opposite-sign operands where the difference takes B's sign.
                w_fin_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SLL, OP_SRA: begin
                w_fin_res = r_a;
                w_fin_co  = r_sco;
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                w_fin_res = r_acc[WIDTH-1:0];
                w_fin_co  = |r_acc[2*WIDTH-1:WIDTH];
`else
                w_fin_err = 1'b1;
`endif
            end
            default: w_fin_err = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_FWD;
            r_cnt    <= '0;
            r_sco    <= 1'b0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_MUL_EN
            r_acc    <= '0;
`endif
        end else if (w_accept) begin
            r_a   <= data1;
            r_b   <= data2;
            r_op  <= operation;
            r_cnt <= w_init_cnt;
            r_sco <= 1'b0;
`ifdef ALU_MUL_EN
            r_acc <= {{WIDTH{1'b0}}, data2};
`endif
        end else if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
                case (r_op)
                    OP_SLL: begin
                        r_sco <= r_a[WIDTH-1];
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                    end
                    OP_SRA: begin
                        r_sco <= r_a[0];
                        r_a   <= {r_a[WIDTH-1], r_a[WIDTH-1:1]};
                    end
`ifdef ALU_MUL_EN
                    OP_MUL: begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
`endif
                    default: r_sco <= r_sco;
                endcase
            end else begin
                r_result <= w_fin_res;
                r_co     <= w_fin_co;
                r_zero   <= (w_fin_res == '0);
                r_ovf    <= w_fin_ovf;
                r_err    <= w_fin_err;
            end
        end
    end

    assign result = r_result;
    assign co     = r_co;
    assign zero   = r_zero;
    assign ovf    = r_ovf;
    assign err    = r_err;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter at WIDTH=8.
// Latency: measured per op as edges from accept to out_valid.
// Backpressure: exercises held out_ready=0 in DONE and early out_ready=1.
module tb_alu_iter;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [2:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         co;
    logic         zero;
    logic         ovf;
    logic         err;

    int total = 0;
    int bad   = 0;

    alu_iter #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .co        (co),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure latency, check result/flags, then complete the handshake.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [W-1:0] res,
                         input logic c, input logic z, input logic o, input logic e,
                         input logic early);
        int n;
        data1     = a;
        data2     = b;
        operation = op;
        in_valid  = 1'b1;
        out_ready = early;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge CLK); #1;
        in_valid  = 1'b0;
        data1     = ~a;
        data2     = ~b;
        operation = ~op;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({tag, ".lat"},  n, lat);
        chk({tag, ".res"},  {24'd0, result}, {24'd0, res});
        chk({tag, ".co"},   {31'd0, co},   {31'd0, c});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z});
        chk({tag, ".ovf"},  {31'd0, ovf},  {31'd0, o});
        chk({tag, ".err"},  {31'd0, err},  {31'd0, e});
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".ir_rise"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        int n;
        RESET     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data1     = '0;
        data2     = '0;
        operation = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Reset state
        chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result",    {24'd0, result},    32'd0);
        chk("rst.flags",     {28'd0, co, zero, ovf, err}, 32'd0);

        // Single-cycle ops
        do_op("fwd", 3'b000, 8'h01, 8'h04, 1, 8'h04, 0, 0, 0, 0, 0);
        do_op("add", 3'b001, 8'h01, 8'h04, 1, 8'h05, 0, 0, 0, 0, 0);
        do_op("and", 3'b010, 8'h01, 8'h04, 1, 8'h00, 0, 1, 0, 0, 0);
        do_op("or",  3'b011, 8'h01, 8'h04, 1, 8'h05, 0, 0, 0, 0, 0);
        do_op("add_ovf",   3'b001, 8'h7F, 8'h01, 1, 8'h80, 0, 0, 1, 0, 0);
        do_op("add_carry", 3'b001, 8'hFF, 8'h01, 1, 8'h00, 1, 1, 0, 0, 0);
        do_op("sub_borrow", 3'b100, 8'h03, 8'h05, 1, 8'hFE, 0, 0, 0, 0, 0);
        do_op("sub_pos",    3'b100, 8'h05, 8'h03, 1, 8'h02, 1, 0, 0, 0, 0);
        do_op("sub_ovf",    3'b100, 8'h80, 8'h01, 1, 8'h7F, 1, 0, 1, 0, 0);
        do_op("sub_eq",     3'b100, 8'h42, 8'h42, 1, 8'h00, 1, 1, 0, 0, 0);

        // Shifts (sll1 with out_ready already high: must still appear once)
        do_op("sll1",  3'b101, 8'h81, 8'h01, 2, 8'h02, 1, 0, 0, 0, 1);
        do_op("sra7",  3'b110, 8'h80, 8'h07, 8, 8'hFF, 0, 0, 0, 0, 0);
        do_op("sra0",  3'b110, 8'h41, 8'h08, 1, 8'h41, 0, 0, 0, 0, 0);
        do_op("sll0",  3'b101, 8'h80, 8'h00, 1, 8'h80, 0, 0, 0, 0, 0);
        do_op("sra3",  3'b110, 8'h7F, 8'h03, 4, 8'h0F, 1, 0, 0, 0, 0);
        do_op("sll4",  3'b101, 8'h1F, 8'h04, 5, 8'hF0, 1, 0, 0, 0, 0);

        // Opcode 111
`ifdef ALU_MUL_EN
        do_op("mul", 3'b111, 8'h10, 8'h11, 9, 8'h10, 1, 0, 0, 0, 0);
        do_op("mul_small", 3'b111, 8'h07, 8'h06, 9, 8'h2A, 0, 0, 0, 0, 0);
`else
        do_op("op7", 3'b111, 8'h10, 8'h11, 1, 8'h00, 0, 1, 0, 1, 0);
`endif

        // Backpressure: ADD 02+03 held in DONE, new op presented throughout
        data1 = 8'h02; data2 = 8'h03; operation = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge CLK); #1;
        data1 = 8'h0C; data2 = 8'h03; operation = 3'b011;   // OR, must wait
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("bp.lat", n, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold_res", {24'd0, result}, 32'h05);
            chk("bp.hold_ov",  {31'd0, out_valid}, 32'd1);
            chk("bp.hold_ir",  {31'd0, in_ready},  32'd0);
            @(posedge CLK); #1;
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;                // edge U
        out_ready = 1'b0;
        chk("bp.u_ov", {31'd0, out_valid}, 32'd0);
        chk("bp.u_ir", {31'd0, in_ready},  32'd1);
        @(posedge CLK); #1;                // edge U+1: OR accepted
        in_valid = 1'b0;
        chk("bp.acc_ir", {31'd0, in_ready}, 32'd0);
        @(posedge CLK); #1;
        chk("bp.or_ov",  {31'd0, out_valid}, 32'd1);
        chk("bp.or_res", {24'd0, result},    32'h0F);
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
        chk("bp.or_done", {31'd0, out_valid}, 32'd0);

        // Reset during the 4th EXEC cycle of a long op
        do_op("pre_rst", 3'b101, 8'h1F, 8'h04, 5, 8'hF0, 1, 0, 0, 0, 0);
`ifdef ALU_MUL_EN
        data1 = 8'h10; data2 = 8'h11; operation = 3'b111;
`else
        data1 = 8'h80; data2 = 8'h07; operation = 3'b110;
`endif
        in_valid = 1'b1;
        @(posedge CLK); #1;                // accept edge T
        in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;                // edge T+4 aborts
        RESET = 1'b0;
        chk("rst_exec.ir",  {31'd0, in_ready},  32'd1);
        chk("rst_exec.ov",  {31'd0, out_valid}, 32'd0);
        chk("rst_exec.res", {24'd0, result},    32'd0);
        chk("rst_exec.flags", {28'd0, co, zero, ovf, err}, 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) n++;
            @(posedge CLK); #1;
        end
        chk("rst_exec.no_ov", n, 0);
        do_op("post_rst", 3'b001, 8'h01, 8'h01, 1, 8'h02, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle ALU for the processor datapath, extending the single-cycle forward/add/and/or ALU. It adds subtract, signed flags, iterative shifts and an optional iterative multiplier. It uses a valid/ready handshake on both sides so the control unit can stall on multi-cycle operations. It sits between the register file read ports and the writeback mux.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  unit can accept an operation.
- data1  in  WIDTH  operand A.
- data2  in  WIDTH  operand B; for shifts, only data2[SHW-1:0] is the shift amount.
- operation  in  3  opcode, latched on input handshake.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  result.
- co  out  1  carry / last bit shifted out / high-half-nonzero.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow (ADD/SUB only).
- err  out  1  unsupported opcode.

## Operation
- Opcodes:
  - 000 FWD: result = data2.
  - 001 ADD: result = data1 + data2.
  - 010 AND.
  - 011 OR.
  - 100 SUB: result = data1 − data2; co = 1 when data1 ≥ data2 (unsigned no-borrow).
  - 101 SLL: logical left shift of data1 by shamt.
  - 110 SRA: arithmetic right shift of data1 by shamt.
  - 111 MUL: low WIDTH bits of the unsigned product.
- Flags:
  - FWD/AND/OR: co = 0, ovf = 0.
  - ADD/SUB: ovf = signed overflow of the WIDTH-bit operation.
  - Shifts: co = last bit shifted out, or 0 when shamt = 0; ovf = 0.
  - MUL: co = |(upper WIDTH bits of the product); ovf = 0.
  - zero is always (result == 0).
  - err = 0 except for the unsupported-opcode case under Configuration.
- States:
  - IDLE: in_ready = 1. On in_valid, latch data1, data2 and operation.
    - FWD/ADD/AND/OR/SUB → DONE.
    - Shift with shamt = 0 → DONE.
    - Shift with shamt > 0 → EXEC, with counter = shamt.
    - MUL → EXEC, with counter = WIDTH.
  - EXEC: one shift step, or one shift-add step for MUL, per cycle; counter decrements by 1. When counter reaches 0, go to DONE.
  - DONE: out_valid = 1; result and flags stable. On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. There is no overlap between operations.
- All arithmetic is modulo 2^WIDTH. The MUL accumulator is 2·WIDTH bits internally.

## Timing
- Reset values: in_ready = 1 after the reset cycle; state IDLE; out_valid = 0; result = 0; co = zero = ovf = err = 0.
- Let T be the input handshake edge.
- Latency to out_valid:
  - FWD/ADD/AND/OR/SUB and shamt = 0 shifts: out_valid high after edge T+1.
  - Shifts with shamt = n > 0: out_valid after edge T+1+n.
  - MUL: out_valid after edge T+1+WIDTH.
- Output handshake on edge U (out_valid & out_ready): out_valid drops and in_ready rises after edge U. The next operation can be accepted at edge U+1.
- out_ready held high early has no effect until DONE. A result is never dropped or duplicated.
- Input changes while not in IDLE are ignored; operands are latched only at T.
- RESET asserted in any state aborts the operation at that edge and returns all outputs to their reset values. Any partial result is discarded.
- RESET has priority over simultaneous in_valid / out_ready.

## Configuration
- ALU_MUL_EN defined: opcode 111 is the iterative multiplier as above.
- ALU_MUL_EN undefined: no multiplier logic is built.
  - Opcode 111 goes IDLE → DONE with latency 1, as a single-cycle opcode.
  - result = 0, err = 1, zero = 1, co = ovf = 0.
- err is 0 for every other opcode in both builds.

## Test plan
- Reset then single-cycle ops, WIDTH=8, data1=0x01, data2=0x04 → FWD 0x04, ADD 0x05, AND 0x00 with zero=1, OR 0x05. Each op: out_valid one cycle after accept.
- ADD 0x7F+0x01 → 0x80, ovf=1, co=0. ADD 0xFF+0x01 → 0x00, co=1, zero=1. SUB 0x03−0x05 → 0xFE, co=0.
- Shifts:
  - SLL 0x81 by 1 → 0x02, co=1, out_valid 2 cycles after accept.
  - SRA 0x80 by 7 → 0xFF, out_valid 8 cycles after accept.
  - shamt=0 → 1-cycle latency, co=0.
- MUL with ALU_MUL_EN: 0x10×0x11 → 0x10, co=1, latency 9 cycles. Without ALU_MUL_EN: opcode 111 → err=1, result=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/flags stable, in_ready=0, new in_valid ignored. Raise out_ready → next op accepted the cycle after.
- RESET pulsed during MUL EXEC cycle 4 → out_valid never rises for that op; outputs zero, in_ready=1 next cycle. A following ADD completes normally.
